// File: rtl/main_memory_block_if.sv
//==============================================================================
// Module      : main_memory_block_if
// Description : Block-transfer bus between the write-through cache and main
//               memory (req/ready/ack handshake, 128-bit blocks).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface main_memory_block_if #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128
);
    logic               mem_req;
    logic               mem_rw;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic               mem_ready;
    logic               mem_ack;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               mem_busy;

    modport master (
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_ready, mem_ack, mem_rdata, mem_busy
    );

    modport slave (
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_ready, mem_ack, mem_rdata, mem_busy
    );
endinterface

`default_nettype wire

// File: rtl/main_memory_block.sv
//==============================================================================
// Module      : main_memory_block
// Description : 64 x 128-bit main memory with fixed LATENCY behind a
//               req/ready/ack handshake. Optional access counters are enabled
//               by defining MAIN_MEM_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module main_memory_block #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128,
    parameter int LATENCY = 4
) (
    input  wire                 clk,
    input  wire                 rst_n,
`ifdef MAIN_MEM_STATS_EN
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count,
`endif
    main_memory_block_if.slave  mem
);

    localparam int c_IDX_LSB = 4;
    localparam int c_IDX_W   = ADDR_W - c_IDX_LSB;
    localparam int c_DEPTH   = 1 << c_IDX_W;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_cnt;
    logic               r_rw;
    logic [c_IDX_W-1:0] r_idx;
    logic [BLOCK_W-1:0] r_wdata;
    logic [BLOCK_W-1:0] r_rdata;
    logic [BLOCK_W-1:0] r_mem [0:c_DEPTH-1];

    logic               w_accept;
    logic               w_enter_ack;
    logic               w_ready;
    logic               w_ack;
    logic               w_busy;
    logic [c_IDX_W-1:0] w_in_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_rd_rw;
    logic               w_unused_addr;

    assign w_in_idx      = mem.mem_addr[c_IDX_LSB +: c_IDX_W];
    assign w_unused_addr = ^mem.mem_addr[c_IDX_LSB-1:0];

    // With LATENCY=1 the ACK is entered straight from IDLE, so the read
    // source is the live bus rather than the captured request.
    assign w_rd_idx = (r_state == c_ST_IDLE) ? w_in_idx   : r_idx;
    assign w_rd_rw  = (r_state == c_ST_IDLE) ? mem.mem_rw : r_rw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_enter_ack = 1'b0;
        w_ready     = 1'b0;
        w_ack       = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                if (mem.mem_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = c_ST_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                w_busy = 1'b1;
                // Counter reaches 0 on this edge, so ACK follows directly.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = c_ST_ACK;
                    w_enter_ack = 1'b1;
                end
            end
            c_ST_ACK: begin
                w_ack       = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_rw    <= mem.mem_rw;
                r_idx   <= w_in_idx;
                r_wdata <= mem.mem_wdata;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_ack && !w_rd_rw) begin
                r_rdata <= r_mem[w_rd_idx];
            end
        end
    end

    // Writes commit only at the end of ACK so a reset during WAIT drops them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == c_ST_ACK) && r_rw) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if (r_state == c_ST_ACK) begin
            if (!r_rw && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (r_rw && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign mem.mem_ready = w_ready;
    assign mem.mem_ack   = w_ack;
    assign mem.mem_busy  = w_busy;
    assign mem.mem_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_main_memory_block.sv
//==============================================================================
// Module      : tb_main_memory_block
// Description : Self-checking bench for main_memory_block: directed table,
//               handshake corner sequences and random traffic vs. array model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_main_memory_block;

    localparam int ADDR_W  = 10;
    localparam int BLOCK_W = 128;
    localparam int LATENCY = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    main_memory_block_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    main_memory_block #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef MAIN_MEM_STATS_EN
        .rd_count (rd_count),
        .wr_count (wr_count),
`endif
        .mem      (bus)
    );

    typedef struct {
        logic         rw;
        logic [9:0]   addr;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [9];
    int           n_vec  = 0;
    int           n_miss = 0;
    logic [127:0] model [64];
    logic [127:0] last_rd;

    localparam logic [127:0] D42  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [127:0] DA   = 128'h0A0A_0A0A_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DC   = 128'hC0C0_FFFF_0000_1234_5678_9ABC_DEF0_0001;
    localparam logic [127:0] D42B = 128'hFEED_FACE_CAFE_BEEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D5   = 128'h5555_0005_5555_0005_5555_0005_5555_0005;
    localparam logic [127:0] D6   = 128'h6666_0006_6666_0006_6666_0006_6666_0006;
    localparam logic [127:0] D9   = 128'h9999_0009_9999_0009_9999_0009_9999_0009;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
        last_rd = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One complete transaction; returns rdata seen in the ack cycle and the
    // number of cycles from the accept cycle to the ack.
    task automatic do_req(input logic rw, input logic [9:0] addr, input logic [127:0] wdata,
                          output logic [127:0] rdata, output int lat);
        int w = 0;
        while (!bus.mem_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        bus.mem_req   = 1'b1;
        bus.mem_rw    = rw;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        @(negedge clk);
        bus.mem_req = 1'b0;
        lat = 1;
        while (!bus.mem_ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.mem_ack) begin
            lat   = -1;
            rdata = 'x;
            return;
        end
        rdata = bus.mem_rdata;
        check("busy_in_ack", 128'(bus.mem_busy), 128'(1));
        check("ready_in_ack", 128'(bus.mem_ready), 128'(0));
        @(negedge clk);
        check("ready_after_ack", 128'(bus.mem_ready), 128'(1));
        check("ack_one_cycle", 128'(bus.mem_ack), 128'(0));
    endtask

    // Model-checked transaction: reads return the stored block, writes leave
    // mem_rdata at the last read value.
    task automatic apply(input logic rw, input logic [9:0] addr, input logic [127:0] wdata);
        logic [127:0] rd;
        logic [127:0] exp;
        int lat;
        exp = rw ? last_rd : model[addr[9:4]];
        do_req(rw, addr, wdata, rd, lat);
        check("latency", 128'(lat), 128'(LATENCY));
        check(rw ? "wr_rdata_held" : "rd_data", rd, exp);
        if (rw) model[addr[9:4]] = wdata;
        else    last_rd = exp;
    endtask

    initial begin
        logic [127:0] rd;
        logic [127:0] wd;
        int lat;
        int acks;
        int t1;
        int t2;

        vecs[0] = '{1'b1, 10'h2A5, D42,  128'h0};
        vecs[1] = '{1'b0, 10'h2A0, '0,   D42};
        vecs[2] = '{1'b1, 10'h050, DA,   D42};
        vecs[3] = '{1'b1, 10'h3F0, DC,   D42};
        vecs[4] = '{1'b0, 10'h3FF, '0,   DC};
        vecs[5] = '{1'b0, 10'h05C, '0,   DA};
        vecs[6] = '{1'b0, 10'h070, '0,   128'h0};
        vecs[7] = '{1'b1, 10'h2AF, D42B, 128'h0};
        vecs[8] = '{1'b0, 10'h2A4, '0,   D42B};

        rst_n         = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_ready", 128'(bus.mem_ready), 128'(1));
        check("rst_ack",   128'(bus.mem_ack),   128'(0));
        check("rst_busy",  128'(bus.mem_busy),  128'(0));
        check("rst_rdata", bus.mem_rdata,       128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // First read after reset
        do_req(1'b0, 10'h000, '0, rd, lat);
        check("first_latency", 128'(lat), 128'(LATENCY));
        check("first_rdata", rd, 128'h0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, lat);
            check("tbl_latency", 128'(lat), 128'(LATENCY));
            check("tbl_rdata", rd, vecs[i].exp);
            if (vecs[i].rw) model[vecs[i].addr[9:4]] = vecs[i].wdata;
            else            last_rd = vecs[i].exp;
        end

        // Back-to-back writes to blocks 5 and 6 with mem_req held high
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = 10'h050;
        bus.mem_wdata = D5;
        acks = 0; t1 = 0; t2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.mem_addr  = 10'h060;
                bus.mem_wdata = D6;
            end
            if (bus.mem_ack) begin
                acks++;
                if (acks == 1) t1 = k;
                if (acks == 2) begin
                    t2 = k;
                    bus.mem_req = 1'b0;
                    check("b2b_rdata_held", bus.mem_rdata, last_rd);
                end
            end
        end
        bus.mem_req = 1'b0;
        check("b2b_ack_count", 128'(acks), 128'(2));
        check("b2b_first_ack", 128'(t1), 128'(LATENCY));
        check("b2b_gap", 128'(t2 - t1), 128'(LATENCY + 1));
        model[5] = D5;
        model[6] = D6;
        apply(1'b0, 10'h050, '0);
        apply(1'b0, 10'h060, '0);
        apply(1'b0, 10'h070, '0);

        // Request pulse and address change during WAIT are ignored
        bus.mem_req  = 1'b1;
        bus.mem_rw   = 1'b0;
        bus.mem_addr = 10'h2A0;
        @(negedge clk);
        bus.mem_req = 1'b0;
        acks = 0;
        rd   = 'x;
        for (int k = 1; k <= 12; k++) begin
            if (bus.mem_ack) begin
                acks++;
                rd = bus.mem_rdata;
            end
            if (k == 1) begin
                bus.mem_addr = 10'h030;
                bus.mem_req  = 1'b1;
            end
            if (k == 2) bus.mem_req = 1'b0;
            @(negedge clk);
        end
        check("ign_ack_count", 128'(acks), 128'(1));
        check("ign_rdata", rd, model[42]);
        last_rd = model[42];

        // Reset two cycles after accepting a write to block 9
        bus.mem_req   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = 10'h090;
        bus.mem_wdata = D9;
        @(negedge clk);
        bus.mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 128'(bus.mem_ready), 128'(1));
        check("mid_rst_busy",  128'(bus.mem_busy),  128'(0));
        check("mid_rst_ack",   128'(bus.mem_ack),   128'(0));
        check("mid_rst_rdata", bus.mem_rdata,       128'h0);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (bus.mem_ack) acks++;
        end
        check("mid_rst_no_ack", 128'(acks), 128'(0));
        model_clear();
        apply(1'b0, 10'h090, '0);
        apply(1'b0, 10'h2A0, '0);

        // Random traffic against the array model
        for (int n = 0; n < 40; n++) begin
            wd = {$urandom, $urandom, $urandom, $urandom};
            apply(1'($urandom_range(0, 1)), 10'($urandom_range(0, 255)), wd);
        end

`ifdef MAIN_MEM_STATS_EN
        pulse_reset();
        check("stats_rst_rd", 128'(rd_count), 128'(0));
        check("stats_rst_wr", 128'(wr_count), 128'(0));
        apply(1'b0, 10'h010, '0);
        apply(1'b1, 10'h020, D5);
        apply(1'b0, 10'h020, '0);
        apply(1'b1, 10'h030, D6);
        apply(1'b0, 10'h030, '0);
        check("stats_rd", 128'(rd_count), 128'(3));
        check("stats_wr", 128'(wr_count), 128'(2));
        pulse_reset();
        check("stats_clr_rd", 128'(rd_count), 128'(0));
        check("stats_clr_wr", 128'(wr_count), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
